// File: rtl/pipeline_stage_elastic.sv
`default_nettype none
// ============================================================================
// Module  : pipeline_stage_elastic
// Brief   : Valid/ready pipeline register with optional 2-entry skid buffer,
//           synchronous flush and saturating stall/bubble statistics.
// Revision: 1.0
// ============================================================================
module pipeline_stage_elastic #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 16,
  parameter int DEPTH  = 2,
  parameter int CNT_W  = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] c_cnt_max = '1;
  localparam bit               c_skid_en = (DEPTH >= 2);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [DATA_W-1:0] r_head_data, w_head_data_nxt;
  logic [CTRL_W-1:0] r_head_ctrl, w_head_ctrl_nxt;
  logic [DATA_W-1:0] r_skid_data, w_skid_data_nxt;
  logic [CTRL_W-1:0] r_skid_ctrl, w_skid_ctrl_nxt;
  logic              w_push;
  logic              w_pop;

  assign out_valid = (r_state != S_EMPTY);
  assign w_push    = in_valid & in_ready;
  assign w_pop     = out_valid & out_ready;

  // Invalid heads present all-zero control so downstream sees a nop.
  assign out_data  = out_valid ? r_head_data : '0;
  assign out_ctrl  = out_valid ? r_head_ctrl : '0;
  assign occupancy = r_state;

  always_comb begin
    w_state_nxt     = r_state;
    w_head_data_nxt = r_head_data;
    w_head_ctrl_nxt = r_head_ctrl;
    w_skid_data_nxt = r_skid_data;
    w_skid_ctrl_nxt = r_skid_ctrl;
    if (flush) begin
      w_state_nxt = S_EMPTY;
    end else begin
      case (r_state)
        S_EMPTY: begin
          if (w_push) begin
            w_state_nxt     = S_ONE;
            w_head_data_nxt = in_data;
            w_head_ctrl_nxt = in_ctrl;
          end
        end
        S_ONE: begin
          if (w_push && w_pop) begin
            w_head_data_nxt = in_data;
            w_head_ctrl_nxt = in_ctrl;
          end else if (w_pop) begin
            w_state_nxt = S_EMPTY;
          end else if (w_push && c_skid_en) begin
            w_state_nxt     = S_FULL;
            w_skid_data_nxt = in_data;
            w_skid_ctrl_nxt = in_ctrl;
          end
        end
        S_FULL: begin
          if (w_pop) begin
            w_state_nxt     = S_ONE;
            w_head_data_nxt = r_skid_data;
            w_head_ctrl_nxt = r_skid_ctrl;
          end
        end
        default: w_state_nxt = S_EMPTY;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state     <= S_EMPTY;
      r_head_data <= '0;
      r_head_ctrl <= '0;
      r_skid_data <= '0;
      r_skid_ctrl <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_head_data <= w_head_data_nxt;
      r_head_ctrl <= w_head_ctrl_nxt;
      r_skid_data <= w_skid_data_nxt;
      r_skid_ctrl <= w_skid_ctrl_nxt;
    end
  end

  generate
    if (DEPTH >= 2) begin : g_skid_ready
      // Ready is a flop so upstream never sees a path from out_ready.
      logic r_in_ready;
      always_ff @(posedge CLK) begin
        if (RST) begin
          r_in_ready <= 1'b1;
        end else begin
          r_in_ready <= (w_state_nxt != S_FULL);
        end
      end
      assign in_ready = r_in_ready;
    end else begin : g_comb_ready
      assign in_ready = !out_valid | out_ready;
    end
  endgenerate

  always_ff @(posedge CLK) begin
    if (RST) begin
      stall_cnt  <= '0;
      bubble_cnt <= '0;
    end else begin
      if (out_valid && !out_ready && stall_cnt != c_cnt_max) begin
        stall_cnt <= stall_cnt + 1'b1;
      end
      if (out_ready && !out_valid && bubble_cnt != c_cnt_max) begin
        bubble_cnt <= bubble_cnt + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pipeline_stage_elastic.sv
`default_nettype none
// ============================================================================
// Module  : tb_pipeline_stage_elastic
// Brief   : Two stages (DEPTH=2/CNT_W=16 and DEPTH=1/CNT_W=4) against a FIFO
//           reference model, directed scenarios followed by random traffic.
// Revision: 1.0
// ============================================================================
module tb_pipeline_stage_elastic;

  logic        CLK;
  logic        RST;
  logic        flush;
  logic [1:0]  in_valid;
  logic [1:0]  in_ready;
  logic [31:0] in_data [2];
  logic [15:0] in_ctrl [2];
  logic [1:0]  out_valid;
  logic [1:0]  out_ready;
  logic [31:0] out_data [2];
  logic [15:0] out_ctrl [2];
  logic [1:0]  occupancy [2];
  logic [15:0] stall_a, bubble_a;
  logic [3:0]  stall_b, bubble_b;

  pipeline_stage_elastic #(.DATA_W(32), .CTRL_W(16), .DEPTH(2), .CNT_W(16)) u_dut_a (
    .CLK(CLK), .RST(RST), .flush(flush),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_data(in_data[0]), .in_ctrl(in_ctrl[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .out_data(out_data[0]), .out_ctrl(out_ctrl[0]),
    .occupancy(occupancy[0]), .stall_cnt(stall_a), .bubble_cnt(bubble_a)
  );

  pipeline_stage_elastic #(.DATA_W(32), .CTRL_W(16), .DEPTH(1), .CNT_W(4)) u_dut_b (
    .CLK(CLK), .RST(RST), .flush(flush),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_data(in_data[1]), .in_ctrl(in_ctrl[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .out_data(out_data[1]), .out_ctrl(out_ctrl[1]),
    .occupancy(occupancy[1]), .stall_cnt(stall_b), .bubble_cnt(bubble_b)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int          n_checks = 0;
  int          n_errors = 0;
  bit          armed = 0;
  bit          blocked [2];
  // Reference: each stage is a FIFO of {data,ctrl} with capacity DEPTH.
  logic [47:0] m_ent [2][2];
  int          m_occ [2];
  int          m_stall [2];
  int          m_bubble [2];
  int          c_max [2] = '{65535, 15};
  int          c_depth [2] = '{2, 1};

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic bit m_ready(input int i);
    if (c_depth[i] == 2) return m_occ[i] < 2;
    return (m_occ[i] == 0) || out_ready[i];
  endfunction

  // Inputs are already driven (at negedge); compare, clock, update model.
  task automatic step();
    logic [47:0] head;
    bit          v, rdy;
    logic [15:0] st, bb;
    #1;
    for (int i = 0; i < 2; i++) begin
      v    = m_occ[i] > 0;
      rdy  = m_ready(i);
      head = v ? m_ent[i][0] : 48'd0;
      st   = (i == 0) ? stall_a  : {12'd0, stall_b};
      bb   = (i == 0) ? bubble_a : {12'd0, bubble_b};
      if (armed) begin
        chk($sformatf("s%0d_out_valid", i), 64'(out_valid[i]), 64'(v));
        chk($sformatf("s%0d_out_data", i), 64'(out_data[i]), 64'(head[47:16]));
        chk($sformatf("s%0d_out_ctrl", i), 64'(out_ctrl[i]), 64'(head[15:0]));
        chk($sformatf("s%0d_in_ready", i), 64'(in_ready[i]), 64'(rdy));
        chk($sformatf("s%0d_occupancy", i), 64'(occupancy[i]), 64'(m_occ[i]));
        chk($sformatf("s%0d_stall_cnt", i), 64'(st), 64'(m_stall[i]));
        chk($sformatf("s%0d_bubble_cnt", i), 64'(bb), 64'(m_bubble[i]));
      end
    end
    @(posedge CLK);
    for (int i = 0; i < 2; i++) begin
      v   = m_occ[i] > 0;
      rdy = m_ready(i);
      blocked[i] = in_valid[i] && !rdy;
      if (RST) begin
        m_occ[i] = 0; m_stall[i] = 0; m_bubble[i] = 0;
      end else begin
        if (v && !out_ready[i] && m_stall[i] < c_max[i]) m_stall[i]++;
        if (out_ready[i] && !v && m_bubble[i] < c_max[i]) m_bubble[i]++;
        if (flush) begin
          m_occ[i] = 0;
        end else begin
          if (v && out_ready[i]) begin
            m_ent[i][0] = m_ent[i][1];
            m_occ[i]--;
          end
          if (in_valid[i] && rdy) begin
            m_ent[i][m_occ[i]] = {in_data[i], in_ctrl[i]};
            m_occ[i]++;
          end
        end
      end
    end
    @(negedge CLK);
  endtask

  task automatic drv(input int i, input bit v, input logic [31:0] d, input bit ordy);
    in_valid[i]  = v;
    in_data[i]   = d;
    in_ctrl[i]   = d[15:0] ^ 16'h5a5a;
    out_ready[i] = ordy;
  endtask

  initial begin
    RST = 1'b1; flush = 1'b0;
    drv(0, 0, 0, 1); drv(1, 0, 0, 1);
    for (int i = 0; i < 2; i++) begin
      m_occ[i] = 0; m_stall[i] = 0; m_bubble[i] = 0; blocked[i] = 0;
    end
    @(negedge CLK);
    step();
    RST = 1'b0;
    armed = 1;

    // Idle with downstream ready: bubbles, 4-bit counter saturates
    for (int k = 0; k < 20; k++) step();
    chk("bubble_sat_b", 64'(bubble_b), 64'd15);
    chk("bubble_cnt_a", 64'(bubble_a), 64'd20);

    // Streaming at full rate
    drv(0, 1, 32'h11, 1); step();
    drv(0, 1, 32'h22, 1); step();
    drv(0, 1, 32'h33, 1); #1;
    chk("stream_occ", 64'(occupancy[0]), 64'd1);
    chk("stream_ready", 64'(in_ready[0]), 64'd1);
    step();
    drv(0, 0, 0, 1); #1;
    chk("stream_last", 64'(out_data[0]), 64'h33);
    step(); step();

    // Back-pressure fills skid buffer
    drv(0, 1, 32'hA, 0); step();
    drv(0, 1, 32'hB, 0); step();
    drv(0, 0, 0, 0); #1;
    chk("full_occ", 64'(occupancy[0]), 64'd2);
    chk("full_ready", 64'(in_ready[0]), 64'd0);
    chk("full_head", 64'(out_data[0]), 64'hA);
    step();
    drv(0, 0, 0, 1); step(); step();
    chk("stall_cnt_a", 64'(stall_a), 64'd2);

    // Flush while full with a same-cycle input
    drv(0, 1, 32'hA, 0); step();
    drv(0, 1, 32'hB, 0); step();
    flush = 1'b1; drv(0, 1, 32'hC, 0); step();
    flush = 1'b0; drv(0, 0, 0, 1); #1;
    chk("flush_valid", 64'(out_valid[0]), 64'd0);
    chk("flush_ctrl", 64'(out_ctrl[0]), 64'd0);
    chk("flush_occ", 64'(occupancy[0]), 64'd0);
    chk("flush_ready", 64'(in_ready[0]), 64'd1);
    step(); step();

    // Single-entry stage: combinational ready
    drv(1, 1, 32'h4, 0); step();
    drv(1, 1, 32'h5, 0); #1;
    chk("d1_blocked", 64'(in_ready[1]), 64'd0);
    step();
    drv(1, 1, 32'h5, 1); #1;
    chk("d1_passthru_ready", 64'(in_ready[1]), 64'd1);
    step();
    drv(1, 0, 0, 1); #1;
    chk("d1_out", 64'(out_data[1]), 64'h5);
    step();

    // Reset while full
    drv(0, 1, 32'hA, 0); step();
    drv(0, 1, 32'hB, 0); step();
    drv(0, 0, 0, 0); RST = 1'b1; step();
    RST = 1'b0; #1;
    chk("rst_occ", 64'(occupancy[0]), 64'd0);
    chk("rst_stall", 64'(stall_a), 64'd0);
    chk("rst_ready", 64'(in_ready[0]), 64'd1);
    step();

    // Random traffic; upstream holds its bundle while blocked
    for (int k = 0; k < 600; k++) begin
      for (int i = 0; i < 2; i++) begin
        if (!blocked[i]) begin
          in_valid[i] = ($urandom_range(0, 99) < 60);
          in_data[i]  = $urandom;
          in_ctrl[i]  = 16'($urandom);
        end
        out_ready[i] = ($urandom_range(0, 99) < 60);
      end
      flush = ($urandom_range(0, 99) < 4);
      RST   = ($urandom_range(0, 199) < 1);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
